// File: rtl/fxp_pkg.sv
// fxp_pkg: shared definitions for the signed fixed-point multiplier slice.
//   - Default integer/fraction bit counts for the Qi.f format.
//   - Rounding-mode and overflow-mode encodings carried with each operation.
//   - fxp_width(): total word width (sign + integer + fraction bits).
package fxp_pkg;

    localparam int FXP_DEF_I = 16;
    localparam int FXP_DEF_F = 15;

    typedef enum logic {
        RND_TRUNC      = 1'b0,   // truncate magnitude toward zero
        RND_HALF_AWAY  = 1'b1    // round half away from zero
    } round_mode_e;

    typedef enum logic {
        OVF_WRAP = 1'b0,         // keep the low W bits of the signed result
        OVF_SAT  = 1'b1          // clamp to the most positive / most negative word
    } ovf_mode_e;

    function automatic int fxp_width(input int int_bits, input int frac_bits);
        return 1 + int_bits + frac_bits;
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// fxp_round_sat: combinational post-processing of an unsigned magnitude product.
// Applies optional half-away-from-zero rounding, drops the F fraction bits,
// detects overflow of the signed W-bit range and either saturates or wraps.
// A zero magnitude always yields 0, so a negative zero is never produced.
// Ports:
//   prod  in  2W+2  unsigned |a|*|b|
//   sign  in  1     1 = result is negative
//   rnd   in  1     rounding mode (round_mode_e)
//   sat   in  1     overflow mode (ovf_mode_e)
//   data  out W     signed Qi.f result
//   ovf   out 1     magnitude exceeded the signed W-bit range
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int  I  = FXP_DEF_I,
    parameter int  F  = FXP_DEF_F,
    localparam int W  = fxp_width(I, F),
    localparam int PW = 2 * W + 2
) (
    input  logic [PW-1:0] prod,
    input  logic          sign,
    input  logic          rnd,
    input  logic          sat,
    output logic [W-1:0]  data,
    output logic          ovf
);

    localparam logic [PW-1:0] ONE_P     = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] HALF_LSB  = ONE_P << (F - 1);
    // A negative result may reach magnitude 2^(W-1); a positive one only 2^(W-1)-1.
    localparam logic [PW-1:0] NEG_LIMIT = ONE_P << (W - 1);
    localparam logic [PW-1:0] POS_LIMIT = NEG_LIMIT - ONE_P;
    localparam logic [W-1:0]  SAT_POS   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  SAT_NEG   = {1'b1, {(W-1){1'b0}}};

    logic [PW-1:0] rounded_s;
    logic [PW-1:0] mag_s;
    logic [W-1:0]  mag_low_s;

    // Round, scale, range-check and select the final signed word.
    always_comb begin
        rounded_s = prod;
        mag_s     = {PW{1'b0}};
        mag_low_s = {W{1'b0}};
        data      = {W{1'b0}};
        ovf       = 1'b0;

        if (round_mode_e'(rnd) == RND_HALF_AWAY) begin
            rounded_s = prod + HALF_LSB;
        end else begin
            rounded_s = prod;
        end

        mag_s     = rounded_s >> F;
        mag_low_s = mag_s[W-1:0];

        if (mag_s == {PW{1'b0}}) begin
            data = {W{1'b0}};
            ovf  = 1'b0;
        end else if (sign) begin
            ovf = (mag_s > NEG_LIMIT);
            if (ovf && (ovf_mode_e'(sat) == OVF_SAT)) begin
                data = SAT_NEG;
            end else begin
                // Negating the low W bits equals the low W bits of the negated magnitude.
                data = {W{1'b0}} - mag_low_s;
            end
        end else begin
            ovf = (mag_s > POS_LIMIT);
            if (ovf && (ovf_mode_e'(sat) == OVF_SAT)) begin
                data = SAT_POS;
            end else begin
                data = mag_low_s;
            end
        end
    end

endmodule

// File: rtl/fixed_point_mult_pipe.sv
// fixed_point_mult_pipe: three-stage pipelined signed Qi.f multiplier with
// valid/ready handshakes on both sides and a sideband tag per operation.
//   S1: result sign and (W+1)-bit operand magnitudes (so -2^(W-1) is exact)
//   S2: unsigned 2W+2-bit magnitude product
//   S3: rounded and saturated/wrapped signed result (the output registers)
// Every stage loads when it is empty or its contents leave in the same cycle,
// giving 1 result per cycle and 3-cycle latency with out_ready held high.
// F must be at least 1.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             input handshake
//   in_a, in_b        [W-1:0]     signed Qi.f operands
//   in_round, in_sat              rounding / overflow mode for this operation
//   in_tag            [TAG_W-1:0] sideband returned with the result
//   out_valid/out_ready           output handshake
//   out_data          [W-1:0]     signed Qi.f product
//   out_ovf                       product exceeded the W-bit range
//   out_tag           [TAG_W-1:0] tag of this result
module fixed_point_mult_pipe
    import fxp_pkg::*;
#(
    parameter int  I     = FXP_DEF_I,
    parameter int  F     = FXP_DEF_F,
    parameter int  TAG_W = 4,
    localparam int W     = fxp_width(I, F)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_round,
    input  logic             in_sat,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PW = 2 * W + 2;

    // Handshake / flow control
    logic s3_free_s;
    logic s2_free_s;
    logic s1_free_s;
    logic in_fire_s;

    // Operand magnitudes
    logic [W:0] a_ext_s;
    logic [W:0] b_ext_s;
    logic [W:0] mag_a_s;
    logic [W:0] mag_b_s;

    // Stage 1
    logic             s1_valid_r;
    logic             s1_sign_r;
    logic [W:0]       s1_mag_a_r;
    logic [W:0]       s1_mag_b_r;
    logic             s1_rnd_r;
    logic             s1_sat_r;
    logic [TAG_W-1:0] s1_tag_r;

    // Stage 2
    logic             s2_valid_r;
    logic [PW-1:0]    s2_prod_r;
    logic             s2_sign_r;
    logic             s2_rnd_r;
    logic             s2_sat_r;
    logic [TAG_W-1:0] s2_tag_r;

    // Round/saturate result feeding stage 3
    logic [W-1:0] rs_data_s;
    logic         rs_ovf_s;

    // A stage is free when empty or when whatever it holds moves on this cycle.
    assign s3_free_s = !out_valid || out_ready;
    assign s2_free_s = !s2_valid_r || s3_free_s;
    assign s1_free_s = !s1_valid_r || s2_free_s;
    assign in_ready  = s1_free_s;
    assign in_fire_s = in_valid && s1_free_s;

    // Sign-extend by one bit and take absolute values without losing -2^(W-1).
    always_comb begin
        a_ext_s = {in_a[W-1], in_a};
        b_ext_s = {in_b[W-1], in_b};
        if (in_a[W-1]) begin
            mag_a_s = {(W+1){1'b0}} - a_ext_s;
        end else begin
            mag_a_s = a_ext_s;
        end
        if (in_b[W-1]) begin
            mag_b_s = {(W+1){1'b0}} - b_ext_s;
        end else begin
            mag_b_s = b_ext_s;
        end
    end

    // Stage valid bits: cleared asynchronously so in-flight work is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            if (s1_free_s) begin
                s1_valid_r <= in_valid;
            end else begin
                s1_valid_r <= s1_valid_r;
            end
            if (s2_free_s) begin
                s2_valid_r <= s1_valid_r;
            end else begin
                s2_valid_r <= s2_valid_r;
            end
            if (s3_free_s) begin
                out_valid <= s2_valid_r;
            end else begin
                out_valid <= out_valid;
            end
        end
    end

    // Stage 1 datapath: capture sign, magnitudes and per-operation modes/tag.
    always_ff @(posedge clk) begin
        if (in_fire_s) begin
            s1_sign_r  <= in_a[W-1] ^ in_b[W-1];
            s1_mag_a_r <= mag_a_s;
            s1_mag_b_r <= mag_b_s;
            s1_rnd_r   <= in_round;
            s1_sat_r   <= in_sat;
            s1_tag_r   <= in_tag;
        end else begin
            s1_sign_r  <= s1_sign_r;
            s1_mag_a_r <= s1_mag_a_r;
            s1_mag_b_r <= s1_mag_b_r;
            s1_rnd_r   <= s1_rnd_r;
            s1_sat_r   <= s1_sat_r;
            s1_tag_r   <= s1_tag_r;
        end
    end

    // Stage 2 datapath: full-width unsigned magnitude product.
    always_ff @(posedge clk) begin
        if (s2_free_s && s1_valid_r) begin
            s2_prod_r <= {{(W+1){1'b0}}, s1_mag_a_r} * {{(W+1){1'b0}}, s1_mag_b_r};
            s2_sign_r <= s1_sign_r;
            s2_rnd_r  <= s1_rnd_r;
            s2_sat_r  <= s1_sat_r;
            s2_tag_r  <= s1_tag_r;
        end else begin
            s2_prod_r <= s2_prod_r;
            s2_sign_r <= s2_sign_r;
            s2_rnd_r  <= s2_rnd_r;
            s2_sat_r  <= s2_sat_r;
            s2_tag_r  <= s2_tag_r;
        end
    end

    fxp_round_sat #(
        .I (I),
        .F (F)
    ) u_round_sat (
        .prod (s2_prod_r),
        .sign (s2_sign_r),
        .rnd  (s2_rnd_r),
        .sat  (s2_sat_r),
        .data (rs_data_s),
        .ovf  (rs_ovf_s)
    );

    // Stage 3 output registers: held stable while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= {W{1'b0}};
            out_ovf  <= 1'b0;
            out_tag  <= {TAG_W{1'b0}};
        end else if (s3_free_s && s2_valid_r) begin
            out_data <= rs_data_s;
            out_ovf  <= rs_ovf_s;
            out_tag  <= s2_tag_r;
        end else begin
            out_data <= out_data;
            out_ovf  <= out_ovf;
            out_tag  <= out_tag;
        end
    end

endmodule

// File: tb/tb_fixed_point_mult_pipe.sv
// Self-checking bench for fixed_point_mult_pipe at default parameters (Q16.15).
// A scoreboard queue holds expected results computed with plain 64-bit
// arithmetic; directed vectors also compare against literal expected words.
module tb_fixed_point_mult_pipe;

    localparam int F     = 15;
    localparam int W     = 32;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             ovf;
        logic [W-1:0]     data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_round;
    logic             in_sat;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_ovf;
    logic [TAG_W-1:0] out_tag;

    fixed_point_mult_pipe #(
        .I     (16),
        .F     (F),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_round  (in_round),
        .in_sat    (in_sat),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   acc_cnt  = 0;
    int   recv_cnt = 0;
    exp_t exp_q[$];

    logic             drv_valid  = 1'b0;
    logic             drv_oready = 1'b1;
    logic [W-1:0]     drv_a      = 32'h0;
    logic [W-1:0]     drv_b      = 32'h0;
    logic             drv_round  = 1'b0;
    logic             drv_sat    = 1'b0;
    logic [TAG_W-1:0] drv_tag    = 4'h0;

    logic         obs_valid;
    logic         obs_ready;
    logic [W-1:0] obs_data;
    logic         obs_ovf;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: exact signed product, then the rounding/overflow rules.
    function automatic exp_t ref_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic rnd, input logic sat,
                                      input logic [TAG_W-1:0] tag);
        longint pa, pb, prod, mag, lim_pos, lim_neg, res;
        logic   neg;
        exp_t   e;
        pa      = longint'($signed(a));
        pb      = longint'($signed(b));
        prod    = pa * pb;
        mag     = (prod < 64'sd0) ? -prod : prod;
        if (rnd) mag = mag + (64'sd1 <<< (F - 1));
        mag     = mag >>> F;
        neg     = a[W-1] ^ b[W-1];
        lim_pos = (64'sd1 <<< (W - 1)) - 64'sd1;
        lim_neg = 64'sd1 <<< (W - 1);
        e.tag   = tag;
        e.ovf   = neg ? (mag > lim_neg) : (mag > lim_pos);
        if (mag == 64'sd0) begin
            e.data = 32'h0;
        end else if (e.ovf && sat) begin
            e.data = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            res    = neg ? -mag : mag;
            e.data = res[W-1:0];
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        logic [W-1:0] corners [6];
        corners[0] = 32'h8000_0000;
        corners[1] = 32'h7FFF_FFFF;
        corners[2] = 32'h0000_0000;
        corners[3] = 32'hFFFF_FFFF;
        corners[4] = 32'h0000_8000;
        corners[5] = 32'hFFFF_8000;
        case ($urandom_range(0, 4))
            0:       v = $urandom;
            1:       v = 32'($signed(16'($urandom)));
            2:       v = corners[$urandom_range(0, 5)];
            3:       v = $signed($urandom) >>> $urandom_range(0, 31);
            default: v = 32'($urandom_range(0, 3)) << $urandom_range(0, 31);
        endcase
        return v;
    endfunction

    // One clock cycle: drive at negedge, sample 1 unit later, score outputs.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        in_valid  = drv_valid;
        in_a      = drv_a;
        in_b      = drv_b;
        in_round  = drv_round;
        in_sat    = drv_sat;
        in_tag    = drv_tag;
        out_ready = drv_oready;
        #1;
        obs_valid = out_valid;
        obs_ready = in_ready;
        obs_data  = out_data;
        obs_ovf   = out_ovf;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            end else begin
                e = exp_q[0];
                check_eq("sb_data", 64'(out_data), 64'(e.data));
                check_eq("sb_ovf",  64'(out_ovf),  64'(e.ovf));
                check_eq("sb_tag",  64'(out_tag),  64'(e.tag));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    recv_cnt++;
                end
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(ref_mult(in_a, in_b, in_round, in_sat, in_tag));
            acc_cnt++;
        end
    endtask

    task automatic drain();
        drv_valid  = 1'b0;
        drv_oready = 1'b1;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_dir(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic rnd, input logic sat,
                           input logic [W-1:0] exp_d, input logic exp_o);
        int lat;
        bit seen;
        drain();
        drv_a      = a;
        drv_b      = b;
        drv_round  = rnd;
        drv_sat    = sat;
        drv_tag    = drv_tag + 4'd1;
        drv_valid  = 1'b1;
        drv_oready = 1'b1;
        tick();
        check_eq({name, "_accept"}, 64'(obs_ready), 64'd1);
        drv_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int n = 1; n <= 10 && !seen; n++) begin
            tick();
            if (obs_valid) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        check_eq({name, "_latency"}, 64'(lat), 64'd3);
        check_eq({name, "_data"}, 64'(obs_data), 64'(exp_d));
        check_eq({name, "_ovf"}, 64'(obs_ovf), 64'(exp_o));
    endtask

    task automatic run_backpressure();
        logic [W-1:0] ops_a [8];
        logic [W-1:0] ops_b [8];
        drain();
        for (int k = 0; k < 8; k++) begin
            ops_a[k] = rand_op();
            ops_b[k] = rand_op();
        end
        acc_cnt  = 0;
        recv_cnt = 0;
        for (int c = 0; c < 60 && recv_cnt < 8; c++) begin
            drv_oready = !(c >= 2 && c <= 6);
            drv_valid  = (acc_cnt < 8);
            drv_a      = ops_a[acc_cnt % 8];
            drv_b      = ops_b[acc_cnt % 8];
            drv_tag    = 4'(acc_cnt);
            drv_round  = acc_cnt[0];
            drv_sat    = acc_cnt[1];
            tick();
            if (c == 4) begin
                check_eq("bp_in_ready_low", 64'(obs_ready), 64'd0);
                check_eq("bp_held_ops", 64'(acc_cnt), 64'd3);
                check_eq("bp_out_valid_held", 64'(obs_valid), 64'd1);
            end
        end
        check_eq("bp_all_received", 64'(recv_cnt), 64'd8);
    endtask

    task automatic run_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            drv_valid  = ($urandom_range(0, 3) != 0);
            drv_oready = ($urandom_range(0, 3) != 0);
            drv_a      = rand_op();
            drv_b      = rand_op();
            drv_round  = 1'($urandom);
            drv_sat    = 1'($urandom);
            drv_tag    = 4'($urandom);
            tick();
        end
        drain();
    endtask

    task automatic run_reset_flight();
        drain();
        drv_oready = 1'b1;
        drv_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drv_a     = rand_op();
            drv_b     = rand_op();
            drv_round = 1'($urandom);
            drv_sat   = 1'($urandom);
            drv_tag   = 4'(k + 8);
            tick();
        end
        drv_valid  = 1'b0;
        drv_oready = 1'b0;
        tick();
        check_eq("flight_out_valid_before_rst", 64'(obs_valid), 64'd1);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check_eq("rst_async_out_valid", 64'(out_valid), 64'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst2_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst2_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst2_out_data", 64'(out_data), 64'd0);
        drv_oready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            check_eq("rst2_no_stale", 64'(obs_valid), 64'd0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 32'h0;
        in_b      = 32'h0;
        in_round  = 1'b0;
        in_sat    = 1'b0;
        in_tag    = 4'h0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_hold_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data",  64'(out_data),  64'd0);
        check_eq("rst_out_ovf",   64'(out_ovf),   64'd0);
        check_eq("rst_out_tag",   64'(out_tag),   64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);

        run_dir("mul_1p5x2",     32'h0000_C000, 32'h0001_0000, 1'b0, 1'b0, 32'h0001_8000, 1'b0);
        run_dir("mul_neg1x1",    32'hFFFF_8000, 32'h0000_8000, 1'b0, 1'b0, 32'hFFFF_8000, 1'b0);
        run_dir("rnd_pos_trunc", 32'h0000_0001, 32'h0000_4000, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        run_dir("rnd_pos_round", 32'h0000_0001, 32'h0000_4000, 1'b1, 1'b0, 32'h0000_0001, 1'b0);
        run_dir("rnd_neg_round", 32'hFFFF_FFFF, 32'h0000_4000, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_dir("rnd_neg_trunc", 32'hFFFF_FFFF, 32'h0000_4000, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        run_dir("ovf_sat",       32'h4000_0000, 32'h0001_0000, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1);
        run_dir("ovf_wrap",      32'h4000_0000, 32'h0001_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1);
        run_dir("min_times_one", 32'h8000_0000, 32'h0000_8000, 1'b0, 1'b1, 32'h8000_0000, 1'b0);
        run_dir("neg_ovf_sat",   32'h8000_0000, 32'h0001_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b1);
        run_dir("zero_sign",     32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0);

        run_backpressure();
        run_random(600);
        run_reset_flight();
        run_dir("after_reset",   32'h0000_C000, 32'h0001_0000, 1'b0, 1'b0, 32'h0001_8000, 1'b0);
        run_random(200);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks so far", pass_cnt, chk_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
